// File: rtl/i2s_serdes.sv
// I2S serializer/deserializer for the CS4272 codec: derives MCLK/SCLK/LRCLK
// from one frame counter, receives 24-bit stereo samples and transmits them back.
module i2s_serdes #(
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              RST_n,
  input  logic              SDout,
  input  logic [DATA_W-1:0] lft_out,
  input  logic [DATA_W-1:0] rht_out,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin,
  output logic [DATA_W-1:0] lft_in,
  output logic [DATA_W-1:0] rht_in,
  output logic              vld
);

  localparam logic [4:0] LAST_SLOT = 5'(DATA_W);

  logic [9:0]        cnt;
  logic [4:0]        slot;
  logic              frame_ok;
  logic              rx_evt, tx_evt, in_word, wrap;
  logic [DATA_W-1:0] rx_shift, rx_word, lft_hold;
  logic [DATA_W-1:0] tx_l, tx_r, tx_shift;

  assign slot    = cnt[8:4];
  assign rx_evt  = (cnt[3:0] == 4'b0111);
  assign tx_evt  = (cnt[3:0] == 4'b1111);
  assign in_word = (slot >= 5'd1) && (slot <= LAST_SLOT);
  assign wrap    = (cnt == 10'h3FF);
  assign rx_word = {rx_shift[DATA_W-2:0], SDout};

  // Codec clocks come straight off counter flops so they never glitch
  assign MCLK  = cnt[1];
  assign SCLK  = cnt[3];
  assign LRCLK = cnt[9];
  assign SDin  = tx_shift[DATA_W-1];

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      cnt      <= 10'h200;
      frame_ok <= 1'b0;
    end else begin
      cnt <= cnt + 10'd1;
      if (wrap)
        frame_ok <= 1'b1;
    end
  end

  // Receive: sample on SCLK rise; the right-half LSB completes the stereo pair
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      rx_shift <= '0;
      lft_hold <= '0;
      lft_in   <= '0;
      rht_in   <= '0;
      vld      <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (rx_evt && in_word) begin
        rx_shift <= rx_word;
        if (slot == LAST_SLOT) begin
          if (!cnt[9])
            lft_hold <= rx_word;
          else if (frame_ok) begin
            lft_in <= lft_hold;
            rht_in <= rx_word;
            vld    <= 1'b1;
          end
        end
      end
    end
  end

  // Transmit: load at the end of slot 0 so the MSB sits in slot 1
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      tx_l     <= '0;
      tx_r     <= '0;
      tx_shift <= '0;
    end else begin
      if (wrap) begin
        tx_l <= lft_out;
        tx_r <= rht_out;
      end
      if (tx_evt) begin
        if (slot == 5'd0)
          tx_shift <= cnt[9] ? tx_r : tx_l;
        else if (in_word)
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: doc/i2s_serdes.md
# i2s_serdes

Codec-side serial interface for the Equalizer datapath. Generates the CS4272 master clocks (MCLK, SCLK, LRCLK) from the system clock. Deserializes the codec's SDout stream into 24-bit left/right samples, with a one-cycle `vld` strobe per frame for the downstream filter banks. Serializes the processed left/right samples back to the codec on SDin in I2S format.

## Interface
- `DATA_W`, 24: sample width per channel, MSB-first.
- `clk  in  1`: system clock, 50 MHz; the only clock in the block.
- `RST_n  in  1`: reset, asynchronous, active-low.
- `SDout  in  1`: serial ADC data from codec, synchronous to our SCLK.
- `lft_out  in  DATA_W`: processed left sample to transmit.
- `rht_out  in  DATA_W`: processed right sample to transmit.
- `MCLK  out  1`: codec master clock, clk/4.
- `SCLK  out  1`: serial bit clock, clk/16.
- `LRCLK  out  1`: frame clock, clk/1024; low = left half, high = right half.
- `SDin  out  1`: serial DAC data to codec.
- `lft_in  out  DATA_W`: last received left sample.
- `rht_in  out  DATA_W`: last received right sample.
- `vld  out  1`: one-clk pulse when `lft_in`/`rht_in` update.

## Operation
- **Frame counter.** A single 10-bit free-running counter `cnt` generates all timing.
  - `MCLK = cnt[1]`, `SCLK = cnt[3]`, `LRCLK = cnt[9]`, all 50% duty.
  - Outputs are driven directly from counter flops (glitch-free).
  - `cnt` resets to `10'h200`, so LRCLK starts high (right half).
- **Bit slots.** `slot = cnt[8:4]`, range 0..31, one slot per SCLK period, 32 slots per half frame.
  - LRCLK toggles coincident with an SCLK falling edge (`cnt[3:0]` 1111→0000).
  - I2S format: the MSB occupies slot 1, the LSB occupies slot 24, and slots 0 and 25..31 are don't-care.
- **Receive path.**
  - Sampling event: `cnt[3:0]==4'b0111`, i.e. the clk edge on which SCLK rises. When `slot` is in 1..24, SDout shifts into a 24-bit shift register, MSB first.
  - At the left-half sampling event of slot 24, the completed word is copied into a left holding register.
  - At the right-half sampling event of slot 24 (`cnt==10'h387`), `lft_in` ← left holding register and `rht_in` ← completed word, on the same edge. `vld` is registered high for exactly the next cycle (`cnt==10'h388`).
  - SDout in slots 0 and 25..31 is ignored.
- **Transmit path.**
  - At the clk edge where `cnt` wraps 0x3FF→0x000 (LRCLK falls), `lft_out` and `rht_out` are captured into tx holding registers.
  - Shift event: `cnt[3:0]==4'b1111` (the SCLK falling edge).
    - At the shift event ending slot 0 of each half, the tx shift register loads that half's holding word.
    - At the shift events ending slots 1..24, it shifts left, zero-filling.
  - `SDin = tx_shift[DATA_W-1]`, so each bit is stable across the following SCLK rise. SDin is 0 in slots 25..31 and slot 0.
- **First-frame gating.** A `frame_ok` flag is cleared by reset and set at the first 0x3FF→0x000 wrap. `vld` is suppressed while the flag is clear, so the partial right half after reset never produces `vld`.
- **No synchronizer on SDout.** The codec drives SDout from our own SCLK, so the input is synchronous to `clk`.

## Timing
- **Reset values:** MCLK=0, SCLK=0, LRCLK=1, SDin=0, vld=0, lft_in=0, rht_in=0; all shift and holding registers are 0.
- **Async reset mid-frame:** all outputs return to reset values immediately. The partial word is discarded and `frame_ok` is cleared.
- **First LRCLK fall:** 512 clks after RST_n deasserts.
- **First vld:** 512+904 = 1416 clks after RST_n deasserts.
- **Subsequent vld pulses:** every 1024 clks.
- **Loopback latency:** a sample pair captured at LRCLK fall of frame N appears on `lft_in`/`rht_in` with the vld of the same frame N, 904 clks later.
- **Output sample rate:** 50 MHz / 1024 = 48.83 kHz.
- **Input sampling:** `lft_out`/`rht_out` are sampled only at the wrap. Changes at any other time take effect at the next frame.

## Test plan
- **Reset:** hold RST_n low for 20 clks, then release.
  - During reset: MCLK=0, SCLK=0, LRCLK=1, SDin=0, vld=0.
  - After release: first LRCLK fall at clk 512, first vld at clk 1416.
- **Clock ratios:** measure MCLK period = 4 clks, SCLK = 16, LRCLK = 1024, each 50% duty. Every LRCLK edge coincides with an SCLK falling edge.
- **Loopback:** tie SDout=SDin with `lft_out=24'hA5A5A5`, `rht_out=24'h5A5A5A`. At the first and every later vld: `lft_in=24'hA5A5A5`, `rht_in=24'h5A5A5A`.
  - Change inputs to `24'h800001`/`24'h7FFFFF` mid-frame. The next vld still shows the old values; the following vld shows the new ones.
- **Don't-care slots:** drive SDout=1 in slots 0 and 25..31 and the pattern `24'h123456` in slots 1..24. `lft_in` must be `24'h123456`, and SDin must be 0 in slots 0 and 25..31.
- **Codec model:** connect to the CS4272 model and compare `lft_in`/`rht_in` at each vld against the model's memory pairs for 4096 frames, with zero mismatches.
- **Mid-frame reset:** assert RST_n low at `cnt=10'h150` for 3 clks.
  - Outputs return to reset values asynchronously.
  - No vld occurs until 1416 clks after release.
  - The old partial word never appears on `lft_in`/`rht_in`.
